// File: rtl/llr_extrinsic_calc.sv
// llr_extrinsic_calc: turns the u=1/u=0 max-metric pair into a scaled, saturated extrinsic LLR
// and a hard decision, with frame addressing and a delay line that aligns the systematic/a-priori inputs.
`default_nettype none

module llr_extrinsic_calc #(
  parameter int MW = 12,
  parameter int LW = 6,
  parameter int EW = 7,
  parameter int KW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] blk_len,
  input  logic          sa_valid,
  input  logic [LW-1:0] sys_in,
  input  logic [LW-1:0] apr_in,
  input  logic          mx_valid,
  input  logic [MW-1:0] max1,
  input  logic [MW-1:0] max0,
  output logic          out_valid,
  output logic [EW-1:0] ext_out,
  output logic          hard_out,
  output logic [KW-1:0] out_addr,
  output logic          out_last,
  output logic          done,
  output logic          align_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic signed [MW+3:0] c_sat_pos = (MW+4)'(2**(EW-1) - 1);
  localparam logic signed [MW+3:0] c_sat_neg = -c_sat_pos;

  state_t state_q, state_d;
  logic [KW-1:0] blk_len_q, blk_len_d;
  logic [KW-1:0] in_cnt_q, in_cnt_d;
  logic [2:0][LW-1:0] sys_dly_q, sys_dly_d;
  logic [2:0][LW-1:0] apr_dly_q, apr_dly_d;
  logic [2:0] sa_dly_q, sa_dly_d;
  logic align_err_q, align_err_d;
  logic done_q, done_d;

  logic s1_valid_q, s1_valid_d;
  logic signed [MW:0]   s1_llr_q, s1_llr_d;
  logic signed [MW+1:0] s1_ext_q, s1_ext_d;
  logic [KW-1:0] s1_addr_q, s1_addr_d;
  logic s1_last_q, s1_last_d;

  logic out_valid_q, out_valid_d;
  logic [EW-1:0] ext_q, ext_d;
  logic hard_q, hard_d;
  logic [KW-1:0] addr_q, addr_d;
  logic last_q, last_d;

  logic accept_w, last_w;
  logic signed [MW:0]   llr_w;
  logic signed [MW+1:0] sys_x_w, apr_x_w, ext_raw_w;
  logic signed [MW+3:0] ext3_w, scaled_w;

  always_comb begin
    accept_w  = (state_q == ST_RUN) && mx_valid;
    last_w    = (in_cnt_q == blk_len_q - KW'(1));
    llr_w     = {max1[MW-1], max1} - {max0[MW-1], max0};
    sys_x_w   = {{(MW+2-LW){sys_dly_q[2][LW-1]}}, sys_dly_q[2]};
    apr_x_w   = {{(MW+2-LW){apr_dly_q[2][LW-1]}}, apr_dly_q[2]};
    ext_raw_w = {llr_w[MW], llr_w} - sys_x_w - apr_x_w;
    // 3*x built as x + 2x; the arithmetic shift then floors toward -inf
    ext3_w    = {{2{s1_ext_q[MW+1]}}, s1_ext_q} + {s1_ext_q[MW+1], s1_ext_q, 1'b0};
    scaled_w  = ext3_w >>> 2;

    state_d     = state_q;
    blk_len_d   = blk_len_q;
    in_cnt_d    = in_cnt_q;
    align_err_d = align_err_q;
    sys_dly_d   = {sys_dly_q[1:0], sys_in};
    apr_dly_d   = {apr_dly_q[1:0], apr_in};
    sa_dly_d    = {sa_dly_q[1:0], sa_valid};

    case (state_q)
      ST_IDLE: if (start && (blk_len != '0)) begin
        state_d   = ST_RUN;
        blk_len_d = blk_len;
        in_cnt_d  = '0;
      end
      ST_RUN: if (accept_w) begin
        in_cnt_d = in_cnt_q + KW'(1);
        if (last_w) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (out_valid_q && last_q) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);

    if (accept_w && !sa_dly_q[2]) align_err_d = 1'b1;

    s1_valid_d = accept_w;
    s1_llr_d   = s1_llr_q;
    s1_ext_d   = s1_ext_q;
    s1_addr_d  = s1_addr_q;
    s1_last_d  = s1_last_q;
    if (accept_w) begin
      s1_llr_d  = llr_w;
      s1_ext_d  = ext_raw_w;
      s1_addr_d = in_cnt_q;
      s1_last_d = last_w;
    end

    out_valid_d = s1_valid_q;
    ext_d       = ext_q;
    hard_d      = hard_q;
    addr_d      = addr_q;
    last_d      = last_q;
    if (s1_valid_q) begin
      if (scaled_w > c_sat_pos)      ext_d = c_sat_pos[EW-1:0];
      else if (scaled_w < c_sat_neg) ext_d = c_sat_neg[EW-1:0];
      else                           ext_d = scaled_w[EW-1:0];
      hard_d = !s1_llr_q[MW] && (s1_llr_q != '0);
      addr_d = s1_addr_q;
      last_d = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_len_q   <= '0;
      in_cnt_q    <= '0;
      sys_dly_q   <= '0;
      apr_dly_q   <= '0;
      sa_dly_q    <= '0;
      align_err_q <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_llr_q    <= '0;
      s1_ext_q    <= '0;
      s1_addr_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      hard_q      <= 1'b0;
      addr_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_len_q   <= blk_len_d;
      in_cnt_q    <= in_cnt_d;
      sys_dly_q   <= sys_dly_d;
      apr_dly_q   <= apr_dly_d;
      sa_dly_q    <= sa_dly_d;
      align_err_q <= align_err_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_llr_q    <= s1_llr_d;
      s1_ext_q    <= s1_ext_d;
      s1_addr_q   <= s1_addr_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      hard_q      <= hard_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ext_out   = ext_q;
  assign hard_out  = hard_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign align_err = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_llr_extrinsic_calc.sv
// tb_llr_extrinsic_calc: scoreboard bench; expected outputs are queued when a sample is driven
// and compared when out_valid appears.
`default_nettype none

module tb_llr_extrinsic_calc;

  localparam int MW = 12;
  localparam int LW = 6;
  localparam int EW = 7;
  localparam int KW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] blk_len = '0;
  logic          sa_valid = 1'b0;
  logic [LW-1:0] sys_in = '0;
  logic [LW-1:0] apr_in = '0;
  logic          mx_valid = 1'b0;
  logic [MW-1:0] max1 = '0;
  logic [MW-1:0] max0 = '0;
  logic          out_valid;
  logic [EW-1:0] ext_out;
  logic          hard_out;
  logic [KW-1:0] out_addr;
  logic          out_last;
  logic          done;
  logic          align_err;

  llr_extrinsic_calc #(.MW(MW), .LW(LW), .EW(EW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
    .sa_valid(sa_valid), .sys_in(sys_in), .apr_in(apr_in),
    .mx_valid(mx_valid), .max1(max1), .max0(max0),
    .out_valid(out_valid), .ext_out(ext_out), .hard_out(hard_out),
    .out_addr(out_addr), .out_last(out_last), .done(done), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ext;
    int hard;
    int addr;
    int last;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_out_cyc = -100;
  int exp_addr = 0;
  int exp_len = 0;
  bit have_out = 0;
  exp_t hold_v;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div4(input int v);
    int q;
    q = v / 4;
    if ((v % 4 != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input int m1, input int m0, input int s, input int a);
    exp_t e;
    int llr, sc;
    llr = m1 - m0;
    sc = floor_div4(3 * (llr - s - a));
    if (sc > 63) sc = 63;
    if (sc < -63) sc = -63;
    e.ext  = sc;
    e.hard = (llr > 0) ? 1 : 0;
    e.addr = exp_addr;
    e.last = (exp_addr == exp_len - 1) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      have_out = 0;
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("ext_out", $signed(ext_out), e.ext);
          chk("hard_out", int'(hard_out), e.hard);
          chk("out_addr", int'(out_addr), e.addr);
          chk("out_last", int'(out_last), e.last);
          hold_v = e;
          have_out = 1;
        end
        last_out_cyc = cyc;
      end else if (have_out) begin
        chk("hold_ext", $signed(ext_out), hold_v.ext);
        chk("hold_addr", int'(out_addr), hold_v.addr);
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc - last_out_cyc, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    tick();
    start = 1'b1;
    blk_len = KW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic frame_start(input int len);
    exp_addr = 0;
    exp_len = len;
    pulse_start(len);
  endtask

  // sa_valid/sys/apr lead mx_valid/max by three cycles
  task automatic send(input int m1, input int m0, input int s, input int a,
                      input bit sa_en, input bit accepted);
    tick();
    sa_valid = sa_en;
    sys_in = LW'(s);
    apr_in = LW'(a);
    tick();
    sa_valid = 1'b0;
    tick();
    tick();
    mx_valid = 1'b1;
    max1 = MW'(m1);
    max0 = MW'(m0);
    if (accepted) begin
      sb_q.push_back(model(m1, m0, s, a));
      exp_addr++;
    end
    tick();
    mx_valid = 1'b0;
  endtask

  task automatic wait_frame(input int done_target);
    int i;
    for (i = 0; i < 200 && !(sb_q.size() == 0 && done_cnt >= done_target); i++) @(posedge clk);
    chk("frame_timeout", (sb_q.size() == 0 && done_cnt == done_target) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_align_err", int'(align_err), 0);
    chk("rst_ext_out", int'(ext_out), 0);
    chk("rst_out_addr", int'(out_addr), 0);

    // nominal single-bit frame
    frame_start(1);
    send(100, 40, 10, 6, 1, 1);
    wait_frame(1);

    // saturation both directions
    frame_start(2);
    send(400, -400, 0, 0, 1, 1);
    send(-400, 400, 0, 0, 1, 1);
    wait_frame(2);

    // floor on a negative tie
    frame_start(1);
    send(0, 0, 1, 0, 1, 1);
    wait_frame(3);

    // start with zero length is ignored: a following mx_valid must produce nothing
    pulse_start(0);
    send(5, 1, 0, 0, 1, 0);
    repeat (5) tick();
    chk("zero_len_done", done_cnt, 3);

    // framing: 6 pulses on a 4-bit frame, stray start mid-frame
    frame_start(4);
    send(10, 0, 1, 1, 1, 1);
    send(-10, 3, 2, -2, 1, 1);
    pulse_start(1);
    send(0, 1, -5, 7, 1, 1);
    send(2047, -2048, -32, 31, 1, 1);
    send(50, 50, 0, 0, 1, 0);
    send(60, 50, 0, 0, 1, 0);
    wait_frame(4);

    // random frame
    frame_start(8);
    for (int k = 0; k < 8; k++)
      send($urandom_range(4000) - 2000, $urandom_range(4000) - 2000,
           $urandom_range(63) - 32, $urandom_range(63) - 32, 1, 1);
    wait_frame(5);

    // mid-frame reset after two samples
    frame_start(4);
    send(30, 10, 1, 1, 1, 1);
    send(-30, 10, 1, 1, 1, 1);
    repeat (3) tick();
    chk("pre_rst_drained", sb_q.size(), 0);
    d0 = done_cnt;
    do_reset();
    send(70, 10, 1, 1, 1, 0);
    repeat (10) tick();
    chk("post_rst_done", done_cnt, d0);
    chk("post_rst_out_valid", int'(out_valid), 0);
    frame_start(1);
    send(-7, 9, 3, -4, 1, 1);
    wait_frame(d0 + 1);

    // misalignment: sample still processed, flag sticky until reset
    chk("align_clear", int'(align_err), 0);
    frame_start(1);
    send(20, 5, 2, 2, 0, 1);
    wait_frame(d0 + 2);
    chk("align_set", int'(align_err), 1);
    repeat (10) tick();
    chk("align_sticky", int'(align_err), 1);
    do_reset();
    chk("align_rst", int'(align_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
